// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and registered empty/full flags.
// A write to a full FIFO is accepted only when a read frees a slot in the same cycle.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  wr_en;
  logic                  rd_en;

  assign wr_en = write & (~full | read);
  assign rd_en = read & ~empty;

  always_comb begin
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage is deliberately not reset; reset only makes old words unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_en) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed vector table plus queue-based
// reference model for the multi-cycle corner cases.
module tb_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          write;
  logic          read;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;

  typedef struct {
    logic          rst;
    logic          write;
    logic          read;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    logic          exp_empty;
    logic          exp_full;
  } vec_t;

  vec_t vecs[15];

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .write (write),
    .read  (read),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle and advance the reference model with the same inputs.
  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    bit wr_ok, rd_ok;
    @(negedge clk);
    rst = r; write = w; read = rd; din = d;
    if (r) begin
      q.delete();
      exp_dout = '0;
    end else begin
      wr_ok = w && ((q.size() < DEPTH) || rd);
      rd_ok = rd && (q.size() > 0);
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mstep(input string name, input logic w, input logic rd, input logic [DW-1:0] d);
    step(1'b0, w, rd, d);
    chk({name, ".dout"}, 32'(dout), 32'(exp_dout));
    chk({name, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({name, ".full"}, 32'(full), 32'(q.size() == DEPTH));
  endtask

  function automatic vec_t mk(logic r, logic w, logic rd, logic [DW-1:0] d,
                              logic [DW-1:0] ed, logic ee, logic ef);
    vec_t v;
    v.rst = r; v.write = w; v.read = rd; v.din = d;
    v.exp_dout = ed; v.exp_empty = ee; v.exp_full = ef;
    return v;
  endfunction

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0; din = '0;

    // Reset with write+read high, read on empty, then the ordering sequence.
    vecs[0]  = mk(1, 1, 1, 8'hEE, 8'h00, 1, 0);
    vecs[1]  = mk(1, 1, 1, 8'hEE, 8'h00, 1, 0);
    vecs[2]  = mk(0, 0, 1, 8'h00, 8'h00, 1, 0);
    vecs[3]  = mk(0, 1, 0, 8'h94, 8'h00, 0, 0);
    vecs[4]  = mk(0, 1, 0, 8'h0F, 8'h00, 0, 0);
    vecs[5]  = mk(0, 1, 0, 8'h51, 8'h00, 0, 0);
    vecs[6]  = mk(0, 1, 0, 8'h24, 8'h00, 0, 0);
    vecs[7]  = mk(0, 1, 0, 8'h67, 8'h00, 0, 0);
    vecs[8]  = mk(0, 1, 0, 8'hF3, 8'h00, 0, 0);
    vecs[9]  = mk(0, 0, 1, 8'h00, 8'h94, 0, 0);
    vecs[10] = mk(0, 0, 1, 8'h00, 8'h0F, 0, 0);
    vecs[11] = mk(0, 0, 1, 8'h00, 8'h51, 0, 0);
    vecs[12] = mk(0, 0, 1, 8'h00, 8'h24, 0, 0);
    vecs[13] = mk(0, 0, 1, 8'h00, 8'h67, 0, 0);
    vecs[14] = mk(0, 0, 1, 8'h00, 8'hF3, 1, 0);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].write, vecs[i].read, vecs[i].din);
      chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].exp_full));
    end

    // Fill, overflow attempt, drain.
    for (int i = 0; i < 8; i++) mstep("fill", 1, 0, 8'(i));
    chk("full_after_8", 32'(full), 32'd1);
    mstep("overflow", 1, 0, 8'hAA);
    for (int i = 0; i < 8; i++) begin
      mstep("drain", 0, 1, 8'h00);
      chk("drain_val", 32'(dout), 32'(i));
    end

    // Underflow: dout must hold 0x07.
    for (int i = 0; i < 3; i++) begin
      mstep("underflow", 0, 1, 8'h00);
      chk("underflow_hold", 32'(dout), 32'h07);
    end
    mstep("uf_wr", 1, 0, 8'h5C);
    mstep("uf_rd", 0, 1, 8'h00);
    chk("uf_new_word", 32'(dout), 32'h5C);

    // Simultaneous ops with 3 stored.
    for (int i = 0; i < 3; i++) mstep("pre3", 1, 0, 8'h30 + 8'(i));
    for (int i = 0; i < 5; i++) mstep("wr_rd_3", 1, 1, 8'h40 + 8'(i));
    chk("count_stays_3", 32'(q.size()), 32'd3);
    // Fill to full, then write+read while full.
    for (int i = 0; i < 5; i++) mstep("to_full", 1, 0, 8'h50 + 8'(i));
    mstep("wr_rd_full", 1, 1, 8'h77);
    chk("wr_rd_full.full", 32'(full), 32'd1);
    chk("wr_rd_full.oldest", 32'(dout), 32'h42);
    for (int i = 0; i < 8; i++) mstep("drain2", 0, 1, 8'h00);
    // Write+read while empty: no fall-through.
    mstep("wr_rd_empty", 1, 1, 8'h99);
    chk("wr_rd_empty.dout_held", 32'(dout), 32'h77);
    chk("wr_rd_empty.empty", 32'(empty), 32'd0);
    mstep("drain3", 0, 1, 8'h00);

    // Wrap-around: 20 writes interleaved with 20 reads.
    for (int i = 0; i < 20; i++) mstep("wrap", 1, (i > 0), 8'hA0 + 8'(i));
    mstep("wrap_last", 0, 1, 8'h00);
    chk("wrap_last_val", 32'(dout), 32'hB3);

    // Mid-run reset with 4 words stored.
    for (int i = 0; i < 4; i++) mstep("pre_rst", 1, 0, 8'hC0 + 8'(i));
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst.dout", 32'(dout), 32'h00);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    mstep("post_rst_wr", 1, 0, 8'h3D);
    mstep("post_rst_rd", 0, 1, 8'h00);
    chk("post_rst_val", 32'(dout), 32'h3D);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer for 8-bit data words. A producer pushes words with `write` and a consumer pops them with `read`. `empty` and `full` flags provide flow control. It decouples stages of the approximate-computing CNN datapath that run in the same clock domain but produce and consume data at different moments.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of each stored word.
- `DEPTH`, default 8: number of storage entries. Must be a power of two and at least 2.
- `ADDR_WIDTH`, default log2(DEPTH) = 3: pointer width. Derived; not overridden independently.

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst`  input  1: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `din`  input  DATA_WIDTH: write data, sampled on a rising edge when a write is accepted.
- `write`  input  1: push request, level-sensitive, evaluated every rising edge.
- `read`  input  1: pop request, level-sensitive, evaluated every rising edge.
- `dout`  output  DATA_WIDTH: registered read data.
- `empty`  output  1: high when the FIFO holds 0 entries.
- `full`  output  1: high when the FIFO holds DEPTH entries.

## Operation
- State:
  - storage array of DEPTH × DATA_WIDTH;
  - write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_WIDTH bits;
  - occupancy counter `count`, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Accepted write (`wr_en`) = `write` & (~`full` | `read`).
  - Effect: `mem[wr_ptr]` <= `din`, and `wr_ptr` increments.
- Accepted read (`rd_en`) = `read` & ~`empty`.
  - Effect: `dout` <= `mem[rd_ptr]`, and `rd_ptr` increments.
- Count update:
  - `count` +1 on write only.
  - `count` −1 on read only.
  - `count` unchanged on both or neither.
- Pointers wrap modulo DEPTH: index DEPTH−1 + 1 → 0.
- Flags are registered and updated in the same edge as `count`:
  - `empty` = (next count == 0);
  - `full` = (next count == DEPTH).
- Boundary rules:
  - Write while full, no read: ignored. Data, pointers, count and flags unchanged; no overflow.
  - Write + read while full: both happen. `dout` gets the oldest word, the new word is stored, and `full` stays 1.
  - Read while empty: ignored. `dout` holds its previous value; pointers unchanged.
  - Write + read while empty: the write happens, the read is ignored (no fall-through). Next cycle `empty` = 0, count = 1.
  - `dout` holds its last popped value whenever no read is accepted.
- Reset (`rst` = 1 at a rising edge) has priority over `write` and `read`:
  - `wr_ptr` = `rd_ptr` = 0, count = 0;
  - `dout` = 0, `empty` = 1, `full` = 0.
  - Storage contents are not cleared and become unreachable.
  - Reset mid-operation discards all stored words.

## Timing
- Write latency: a word written at edge N is readable from edge N+1. `empty` falls after edge N.
- Read latency: one cycle. With `read` high at edge N and the FIFO not empty, `dout` shows the word after edge N.
- Sustained throughput: one write and one read per cycle.
- Flags reflect the state after the most recent edge. There is no combinational path from `write`/`read` to `empty`/`full`/`dout`.
- Inputs must be stable around the rising edge; no other handshake exists.

## Test plan
- Reset: hold `rst` = 1 for 2 edges with `write` = `read` = 1 → `dout` = 0x00, `empty` = 1, `full` = 0, no data stored.
- Order: write 0x94, 0x0F, 0x51, 0x24, 0x67, 0xF3 on consecutive edges, then read 6 times → `dout` = 0x94, 0x0F, 0x51, 0x24, 0x67, 0xF3 in order, one per edge. `empty` = 1 after the sixth read.
- Full/overflow: write 0x00..0x07 → `full` = 1 after the 8th write. A 9th write of 0xAA is dropped. Reading 8 words returns 0x00..0x07, never 0xAA.
- Underflow: on an empty FIFO whose last popped value is 0x07, assert `read` for 3 edges → `dout` stays 0x07, `empty` stays 1, and a subsequent write/read returns the new word correctly.
- Simultaneous ops:
  - With 3 words stored, `write` + `read` for 5 edges → count stays 3, flags unchanged, output stays in FIFO order.
  - With the FIFO full, `write` + `read` → `full` stays 1 and the oldest word appears on `dout`.
  - With the FIFO empty, `write` + `read` → `empty` = 0 and `dout` unchanged.
- Wrap-around and mid-run reset:
  - Run 20 writes and 20 interleaved reads so both pointers wrap twice → data order preserved.
  - Assert `rst` with 4 words stored → `empty` = 1 and `dout` = 0x00. The next write/read pair returns only the new word.
